viterbi_frame_ctrl: RTL
=======================

# viterbi_frame_ctrl

Frame sequencer and scorer for the encoder → channel → Viterbi decoder datapath. Generates one frame of pseudo-random data bits plus flush tail into the convolutional encoder and schedules channel error injection. It then scores the decoder output against a latency-aligned copy of the sent bits. It replaces free-running testbench stimulus so that bit-error-rate runs are repeatable and self-checking.

## Interface
Parameters:
- FRAME_LEN, 256: data bits per frame (1..65535)
- TAIL, 2: flush zeros after data (K-1)
- DEC_LAT, 32: cycles from an encoder input bit to its decoded bit on decoder_i; DEC_LAT ≥ TAIL
- ENC_LAT, 1: cycles from the encoder enable cycle to the matching encoder output symbol
- N, 4: error period exponent; one injected symbol every 2**N symbols
- SEED, 16'hACE1: LFSR reset value, nonzero

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  begin a frame; sampled only in IDLE
- err_en_i  in  1  enable error injection; sampled every cycle
- decoder_i  in  1  decoded bit from the decoder
- enable_encoder_o  out  1  encoder enable
- encoder_o  out  1  bit into the encoder
- err_inj_o  out  2  XOR mask for the channel symbol
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle end-of-frame pulse
- bit_err_ct_o  out  16  decoded bits mismatching sent bits
- inj_ct_o  out  16  symbols injected this frame

## Operation
- FSM states: IDLE, SEND, FLUSH, DRAIN, DONE.
- IDLE → SEND on start_i. At that transition, clear both counters, the symbol counter and the compare counter.
- SEND lasts FRAME_LEN cycles: enable_encoder_o=1 and encoder_o=LFSR bit 0.
- Data source is a 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances once per SEND cycle, is not reseeded between frames, and is reset to SEED.
- FLUSH lasts TAIL cycles: enable_encoder_o=1 and encoder_o=0.
- DRAIN: enable_encoder_o=0. Move to DONE when the compare counter reaches FRAME_LEN.
- DONE lasts 1 cycle: done_o=1, then return to IDLE.
- Symbol counter sym_ct counts SEND+FLUSH cycles, starting at 0.
- Injection: a symbol is injected when err_en_i=1 and sym_ct[N-1:0] is all ones.
  - Its mask 2'b01 appears on err_inj_o exactly ENC_LAT cycles later.
  - err_inj_o is 2'b00 at all other times.
  - inj_ct_o increments in the cycle err_inj_o≠0.
- Reference path: a DEC_LAT-deep delay line carries each sent data bit with a valid flag. Valid=1 in SEND only; FLUSH bits carry valid=0.
- Scoring: when the delay-line output is valid, increment the compare counter. If decoder_i differs from the delayed bit, also increment bit_err_ct_o.
- Counters saturate at 16'hFFFF. They hold their value after DONE until the next start.
- start_i is ignored outside IDLE. err_en_i changes take effect mid-frame on the next symbol.
- rst low at any time, including mid-frame, forces IDLE immediately:
  - all outputs 0
  - counters 0
  - delay line cleared
  - LFSR=SEED

## Timing
- Cycle 0 is the cycle start_i is sampled high in IDLE.
- SEND occupies cycles 1..FRAME_LEN. FLUSH occupies cycles FRAME_LEN+1..FRAME_LEN+TAIL.
- Data bit k is sent in cycle k+1 and compared in cycle k+1+DEC_LAT.
- The last compare is in cycle FRAME_LEN+DEC_LAT.
- done_o is high in cycle FRAME_LEN+DEC_LAT+1, with final counter values visible in that same cycle.
- busy_o is high in cycles 1..FRAME_LEN+DEC_LAT and low during done_o.
- Earliest next start_i is the cycle after done_o.
- Reset values: enable_encoder_o=0, encoder_o=0, err_inj_o=2'b00, busy_o=0, done_o=0, bit_err_ct_o=0, inj_ct_o=0.

## Structure
- Package viterbi_ctrl_pkg holds:
  - state enum typedef (IDLE, SEND, FLUSH, DRAIN, DONE)
  - LFSR tap constant
  - default SEED
  - counter width constant (16)
- Sub-module ref_delay_line (parameter DEPTH, 2-bit data+valid, async active-low reset) holds the aligned reference bits.
- The FSM, counters, LFSR and injection scheduling live in the top module.

## Test plan
- Reset: assert rst low mid-SEND. All outputs go to 0 immediately and the FSM returns to IDLE. After release, a new frame reproduces the first-frame LFSR sequence starting from SEED.
- Clean loopback: decoder_i is modelled as encoder_o delayed DEC_LAT cycles, with err_en_i=0 and defaults. Required: done_o in cycle 289, bit_err_ct_o=0, inj_ct_o=0.
- Injection schedule: err_en_i=1, N=4, FRAME_LEN=256, TAIL=2. Required: inj_ct_o=16, and err_inj_o=2'b01 in cycles 17, 33, …, 257 (sym_ct 15, 31, …, 255; ENC_LAT=1).
- Scoring: the loopback model flips every 64th decoded bit (k=63, 127, 191, 255). Required: bit_err_ct_o=4. TAIL bits are never scored.
- Busy handling: pulse start_i in cycles 5 and 100 of a frame. Both pulses are ignored, and exactly one done_o is produced.
- Back-to-back: start_i is asserted the cycle after done_o. Counters clear at the start of the second frame, and its data continues the LFSR sequence without reseeding.

Source files
------------

// File: rtl/viterbi_frame_ctrl_pkg.sv
// Shared types and constants for the Viterbi frame sequencer/scorer.
// The LFSR step and counter saturation helpers live here so the top stays readable.
package viterbi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int          CNT_W        = 16;
  // Right-shifting Fibonacci form: taps 16,14,13,11 map to state bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Handshake/data bundle between the frame controller and the encoder/channel/decoder side.
interface viterbi_frame_ctrl_if;
  import viterbi_ctrl_pkg::*;

  logic             start_i;
  logic             err_en_i;
  logic             decoder_i;
  logic             enable_encoder_o;
  logic             encoder_o;
  logic [1:0]       err_inj_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] bit_err_ct_o;
  logic [CNT_W-1:0] inj_ct_o;

  modport master (
    output start_i, err_en_i, decoder_i,
    input  enable_encoder_o, encoder_o, err_inj_o, busy_o, done_o, bit_err_ct_o, inj_ct_o
  );

  modport slave (
    input  start_i, err_en_i, decoder_i,
    output enable_encoder_o, encoder_o, err_inj_o, busy_o, done_o, bit_err_ct_o, inj_ct_o
  );
endinterface

// File: rtl/viterbi_frame_ctrl_ref_delay_line.sv
// Fixed-latency shift line carrying {valid, bit} of each sent symbol to the scorer.
module ref_delay_line #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_line
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [1:0] r_q;
        logic [1:0] w_d;
        if (gi == 0) begin : g_src
          assign w_d = i_d;
        end else begin : g_src
          assign w_d = g_stage[gi-1].r_q;
        end
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) r_q <= 2'b00;
          else      r_q <= w_d;
        end
      end
      assign o_q = g_stage[DEPTH-1].r_q;
    end
  endgenerate

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: drives LFSR data + flush tail into the encoder, schedules channel
// error injection, and scores decoder output against a latency-aligned reference.
module viterbi_frame_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int          FRAME_LEN = 256,
  parameter int          TAIL      = 2,
  parameter int          DEC_LAT   = 32,
  parameter int          ENC_LAT   = 1,
  parameter int          N         = 4,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst,
  viterbi_frame_ctrl_if.slave bus
);

  state_t           r_state, w_next_state;
  logic [15:0]      r_lfsr;
  logic [31:0]      r_sym_ct;
  logic [CNT_W-1:0] r_cmp_ct, r_err_ct, r_inj_ct;
  logic             w_start, w_send, w_in_tx, w_inj_now, w_inj_out, w_cmp_last;
  logic             w_enable, w_enc_bit, w_busy, w_done;
  logic [1:0]       w_dly;

  assign w_start    = (r_state == IDLE) && bus.start_i;
  assign w_send     = (r_state == SEND);
  assign w_in_tx    = w_send || (r_state == FLUSH);
  assign w_inj_now  = w_in_tx && bus.err_en_i && (&r_sym_ct[N-1:0]);
  // Last compare happens this cycle, so DONE lands exactly one cycle after it.
  assign w_cmp_last = w_dly[1] && (r_cmp_ct == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_start) w_next_state = SEND;
      SEND:  if (w_cmp_last) w_next_state = DONE;
             else if (r_sym_ct == 32'(FRAME_LEN - 1)) w_next_state = (TAIL == 0) ? DRAIN : FLUSH;
      FLUSH: if (w_cmp_last) w_next_state = DONE;
             else if (r_sym_ct == 32'(FRAME_LEN + TAIL - 1)) w_next_state = DRAIN;
      DRAIN: if (w_cmp_last) w_next_state = DONE;
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_enable  = 1'b0;
    w_enc_bit = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      SEND:  begin w_enable = 1'b1; w_enc_bit = r_lfsr[0]; w_busy = 1'b1; end
      FLUSH: begin w_enable = 1'b1; w_busy = 1'b1; end
      DRAIN: w_busy = 1'b1;
      DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.enable_encoder_o = w_enable;
  assign bus.encoder_o        = w_enc_bit;
  assign bus.busy_o           = w_busy;
  assign bus.done_o           = w_done;
  assign bus.err_inj_o        = {1'b0, w_inj_out};
  assign bus.bit_err_ct_o     = r_err_ct;
  assign bus.inj_ct_o         = r_inj_ct;

  // Injection decision is made on the symbol index, then aligned to the encoder output.
  generate
    if (ENC_LAT == 0) begin : g_inj_comb
      assign w_inj_out = w_inj_now;
    end else begin : g_inj_pipe
      logic [ENC_LAT-1:0] r_inj_pipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_inj_pipe <= '0;
        end else begin
          r_inj_pipe[0] <= w_inj_now;
          for (int i = 1; i < ENC_LAT; i++) r_inj_pipe[i] <= r_inj_pipe[i-1];
        end
      end
      assign w_inj_out = r_inj_pipe[ENC_LAT-1];
    end
  endgenerate

  ref_delay_line #(.DEPTH(DEC_LAT)) u_ref_dly (
    .clk (clk),
    .rst (rst),
    .i_d ({w_send, w_enc_bit}),
    .o_q (w_dly)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_lfsr <= SEED;
    else if (w_send) r_lfsr <= lfsr_step(r_lfsr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym_ct <= '0;
      r_cmp_ct <= '0;
      r_err_ct <= '0;
      r_inj_ct <= '0;
    end else if (w_start) begin
      r_sym_ct <= '0;
      r_cmp_ct <= '0;
      r_err_ct <= '0;
      r_inj_ct <= '0;
    end else begin
      if (w_in_tx) r_sym_ct <= r_sym_ct + 32'd1;
      if (w_dly[1]) begin
        r_cmp_ct <= sat_inc(r_cmp_ct);
        if (bus.decoder_i != w_dly[0]) r_err_ct <= sat_inc(r_err_ct);
      end
      if (w_inj_out) r_inj_ct <= sat_inc(r_inj_ct);
    end
  end

endmodule
